// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// The magnitude helper is sized for the XLEN-wide register file the unit sits beside.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    WB
  } state_t;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath for the multiply/divide unit: 2*WIDTH accumulator, one shift-add or
// restoring shift-subtract step per cycle, and the iteration counter. Honours MULDIV_EARLY_OUT_EN.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               start,
  input  logic               step,
  input  logic               is_div,
  input  logic               div_zero,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic               last,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               div_mode;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               fits;

  // Divide keeps {remainder, quotient} in acc; the divisor sits in the low half of addend.
  always_comb begin
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    fits     = rem_sh >= {1'b0, addend[WIDTH-1:0]};
    rem_diff = rem_sh[WIDTH-1:0] - addend[WIDTH-1:0];
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign last = (cnt == '0) || (!div_mode && (mplier[WIDTH-1:1] == '0));
`else
  assign last = (cnt == '0);
`endif

  always_ff @(posedge clock) begin
    if (start) begin
      div_mode <= is_div;
      cnt      <= div_zero ? '0 : CNT_W'(WIDTH - 1);
      mplier   <= mag_b;
      if (is_div) begin
        acc    <= {{WIDTH{1'b0}}, mag_a};
        addend <= {{WIDTH{1'b0}}, mag_b};
      end else begin
        acc    <= '0;
        addend <= {{WIDTH{1'b0}}, mag_a};
      end
    end else if (step) begin
      cnt <= cnt - CNT_W'(1);
      if (div_mode) begin
        acc <= fits ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                    : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        if (mplier[0]) acc <= acc + addend;
        addend <= addend << 1;
        mplier <= {1'b0, mplier[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide execution stage: FSM, request/writeback handshakes and sign fix-up.
// Optional MULDIV_EARLY_OUT_EN shortens multiplies with small multipliers (see muldiv_core).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  hi_out,
  output logic [WIDTH-1:0]  lo_out,
  output logic              busy
);

  state_t              state, state_nxt;
  op_t                 op_in;
  logic                accept, is_div_in, signed_in, div_zero_in, last;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [2*WIDTH-1:0]  acc, prod;
  logic                div_r, dz_r, neg_q_r, neg_r_r;
  logic [WIDTH-1:0]    a_r, hi_r, lo_r, fix_hi, fix_lo;
  logic [ADDR_W-1:0]   dest_r;

  assign op_in       = op_t'(op);
  assign is_div_in   = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign signed_in   = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign accept      = in_valid && (state == IDLE);
  assign div_zero_in = is_div_in && (operand_b == '0);
  assign mag_a       = abs_val(operand_a, signed_in);
  assign mag_b       = abs_val(operand_b, signed_in);

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clock    (clock),
    .start    (accept),
    .step     (state == CALC),
    .is_div   (is_div_in),
    .div_zero (div_zero_in),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .last     (last),
    .acc      (acc)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    wb_valid  = (state == WB);
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last) state_nxt = FIX;
      FIX:     state_nxt = (dest_r == '0) ? IDLE : WB;
      WB:      if (wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divide-by-zero still passes one dummy CALC cycle; its result is overridden here.
  always_comb begin
    prod   = neg_q_r ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (div_r) begin
      fix_lo = neg_q_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = neg_r_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
    if (dz_r) begin
      fix_lo = '1;
      fix_hi = a_r;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      div_r   <= is_div_in;
      dz_r    <= div_zero_in;
      neg_q_r <= signed_in && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      neg_r_r <= signed_in && operand_a[WIDTH-1];
      a_r     <= operand_a;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dest_r <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      if (accept) dest_r <= dest_addr;
      if (state == FIX) begin
        hi_r <= fix_hi;
        lo_r <= fix_lo;
      end
    end
  end

  assign wb_addr = dest_r;
  assign wb_data = lo_r;
  assign hi_out  = hi_r;
  assign lo_out  = lo_r;
  assign busy    = ~in_ready;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: transaction-level reference model compared every cycle,
// plus literal expectations for the documented corner cases.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        wb_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  dest_addr = '0;
  logic        in_ready, wb_valid, busy;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, hi_out, lo_out;

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;
  bit mon_en = 1'b0;

  // Reference model state
  bit          m_busy = 1'b0;
  bit          m_wb = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [4:0]  m_addr = '0;
  logic [63:0] p_res = '0;
  int          m_done = 0;

  muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .dest_addr (dest_addr),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // {HI, LO} from plain arithmetic
  function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, m;
    logic [63:0] r, qv, mv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00:   r = 64'(sa * sb);
      2'b01:   r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          qv = q;
          mv = m;
          r = {mv[31:0], qv[31:0]};
        end
      end
      default: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  // Cycles from accept to first wb_valid
  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[1] && b == 32'd0) return 3;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      logic [31:0] mb;
      int hb;
      mb = (o == 2'b00 && b[31]) ? -b : b;
      hb = 0;
      for (int i = 0; i < 32; i++) if (mb[i]) hb = i;
      return hb + 3;
    end
`endif
    if (a == 32'hDEAD_0000) return 34;
    return 34;
  endfunction

  always @(posedge clock) begin
    ecnt <= ecnt + 1;
    if (reset) begin
      m_busy <= 1'b0;
      m_wb   <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_addr <= '0;
    end else if (m_busy) begin
      if (m_wb) begin
        if (wb_ready) begin
          m_wb   <= 1'b0;
          m_busy <= 1'b0;
        end
      end else if (ecnt + 1 == m_done) begin
        m_hi <= p_res[63:32];
        m_lo <= p_res[31:0];
        if (m_addr != 5'd0) m_wb <= 1'b1;
        else                m_busy <= 1'b0;
      end
    end else if (in_valid) begin
      p_res  <= model_res(op, operand_a, operand_b);
      m_done <= ecnt + model_lat(op, operand_a, operand_b);
      m_busy <= 1'b1;
      m_addr <= dest_addr;
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("wb_valid", wb_valid, m_wb);
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
      chk("wb_data", wb_data, m_lo);
      chk("wb_addr", wb_addr, m_addr);
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input int hold, output int lat, output logic [4:0] wa);
    int n;
    int ta;
    int h;
    h   = hold;
    lat = -1;
    wa  = '0;
    n   = 0;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk("idle_timeout", in_ready, 1'b1);
    op = o; operand_a = a; operand_b = b; dest_addr = d;
    in_valid = 1'b1;
    wb_ready = (h == 0);
    @(posedge clock);
    #1 ta = ecnt;
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    while (n < 200) begin
      if (wb_valid && lat < 0) begin
        lat = ecnt - ta + 1;
        wa  = wb_addr;
      end
      if (wb_valid && h > 0) begin
        h--;
        in_valid  = 1'b1;
        op        = 2'b01;
        operand_a = $urandom;
        dest_addr = 5'd7;
        if (h == 0) begin
          in_valid = 1'b0;
          wb_ready = 1'b1;
        end
      end
      if (in_ready) break;
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("op_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
    wb_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [4:0]  wa;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [4:0]  d;
    bit          saw;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    mon_en = 1'b1;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, lat, wa);
    chk("multu_max_hi", hi_out, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo_out, 32'h0000_0001);
    chk("multu_max_lat", lat, 34);
    chk("multu_max_addr", wa, 5'd5);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 5'd3, 0, lat, wa);
    chk("mult_neg_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo_out, 32'hFFFF_FFEB);

    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, lat, wa);
    chk("div_neg_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi_out, 32'hFFFF_FFFF);

    do_op(2'b11, 32'd100, 32'd7, 5'd8, 0, lat, wa);
    chk("divu_lo", lo_out, 32'd14);
    chk("divu_hi", hi_out, 32'd2);

    do_op(2'b11, 32'd5, 32'd0, 5'd8, 0, lat, wa);
    chk("divz_lo", lo_out, 32'hFFFF_FFFF);
    chk("divz_hi", hi_out, 32'd5);
    chk("divz_lat", lat, 3);

    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 0, lat, wa);
    chk("div_ovf_lo", lo_out, 32'h8000_0000);
    chk("div_ovf_hi", hi_out, 32'd0);

    do_op(2'b01, 32'd6, 32'd7, 5'd9, 5, lat, wa);
    chk("hold_lo", lo_out, 32'd42);
    chk("hold_addr", wa, 5'd9);

    do_op(2'b01, 32'd3, 32'd4, 5'd0, 0, lat, wa);
    chk("dest0_lo", lo_out, 32'd12);
    chk("dest0_no_wb", lat < 0, 1'b1);

    do_op(2'b01, 32'd9, 32'd1, 5'd4, 0, lat, wa);
    chk("mul9x1_lo", lo_out, 32'd9);
`ifdef MULDIV_EARLY_OUT_EN
    chk("mul9x1_lat", lat, 3);
`else
    chk("mul9x1_lat", lat, 34);
`endif

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 3));
        3: b = 32'($urandom_range(0, 300));
        default: b = $urandom;
      endcase
      d = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(o, a, b, d, $urandom_range(0, 3), lat, wa);
      if (d != 5'd0) chk("rand_lat", lat, model_lat(o, a, b));
      else           chk("rand_dest0_no_wb", lat < 0, 1'b1);
    end

    // Reset in the middle of CALC discards the operation.
    op = 2'b01; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0; dest_addr = 5'd4;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_hi", hi_out, 32'd0);
    chk("midrst_lo", lo_out, 32'd0);
    saw = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (wb_valid) saw = 1'b1;
    end
    chk("midrst_no_wb", saw, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
